// File: rtl/rocev2_mem_cmd_responder.sv
// Behavioural host-memory responder for the RoCEv2 read/write command interfaces.
// Optional forced read stalls are compiled in with `define MEM_RESP_STALL_EN.
module rocev2_mem_cmd_responder #(
    parameter int unsigned MEM_WORDS    = 1024,
    parameter int unsigned STALL_PERIOD = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [95:0]    s_axis_mem_read_cmd_tdata,
    input  logic           s_axis_mem_read_cmd_tvalid,
    output logic           s_axis_mem_read_cmd_tready,
    output logic [511:0]   m_axis_mem_read_data_tdata,
    output logic [63:0]    m_axis_mem_read_data_tkeep,
    output logic           m_axis_mem_read_data_tlast,
    output logic           m_axis_mem_read_data_tvalid,
    input  logic           m_axis_mem_read_data_tready,
    input  logic [95:0]    s_axis_mem_write_cmd_tdata,
    input  logic           s_axis_mem_write_cmd_tvalid,
    output logic           s_axis_mem_write_cmd_tready,
    input  logic [511:0]   s_axis_mem_write_data_tdata,
    input  logic [63:0]    s_axis_mem_write_data_tkeep,
    input  logic           s_axis_mem_write_data_tvalid,
    output logic           s_axis_mem_write_data_tready
);
    localparam int unsigned DATA_W = 512;
    localparam int unsigned KEEP_W = 64;
    localparam int unsigned BEAT_W = 27;
    localparam int unsigned IDX_W  = $clog2(MEM_WORDS);
    localparam int unsigned CNT_W  = $clog2(STALL_PERIOD + 1);
`ifdef MEM_RESP_STALL_EN
    localparam bit StallEn = 1'b1;
`else
    localparam bit StallEn = 1'b0;
`endif

    typedef enum logic [1:0] {RD_IDLE, RD_LOAD, RD_STREAM} rd_state_e;
    typedef enum logic       {WR_IDLE, WR_DATA} wr_state_e;

    function automatic logic [BEAT_W-1:0] beats_of(input logic [31:0] len);
        return BEAT_W'(len[31:6]) + BEAT_W'(|len[5:0]);
    endfunction

    function automatic logic [KEEP_W-1:0] last_keep_of(input logic [5:0] rem);
        return (rem == 6'd0) ? '1 : (KEEP_W'(1) << rem) - KEEP_W'(1);
    endfunction

    logic [DATA_W-1:0] mem_q [MEM_WORDS];

    rd_state_e          rd_state_q;
    logic [IDX_W-1:0]   rd_idx_q;
    logic [BEAT_W-1:0]  rd_rem_q;
    logic [KEEP_W-1:0]  rd_last_keep_q;
    logic [CNT_W-1:0]   rd_cnt_q;
    logic               rd_stall_q;
    logic               rd_cmd_rdy_q;
    logic [DATA_W-1:0]  rd_tdata_q;
    logic [KEEP_W-1:0]  rd_tkeep_q;
    logic               rd_tlast_q;
    logic               rd_tvalid_q;

    wr_state_e          wr_state_q;
    logic [IDX_W-1:0]   wr_idx_q;
    logic [BEAT_W-1:0]  wr_rem_q;
    logic               wr_cmd_rdy_q;
    logic               wr_data_rdy_q;

    logic [BEAT_W-1:0]  rd_cmd_beats_c;
    logic [BEAT_W-1:0]  wr_cmd_beats_c;
    logic [KEEP_W-1:0]  rd_load_keep_c;
    logic               rd_cmd_fire_c;
    logic               rd_beat_fire_c;
    logic               wr_cmd_fire_c;
    logic               wr_data_fire_c;
    logic               unused_bits_c;

    assign rd_cmd_beats_c = beats_of(s_axis_mem_read_cmd_tdata[95:64]);
    assign wr_cmd_beats_c = beats_of(s_axis_mem_write_cmd_tdata[95:64]);
    assign rd_load_keep_c = (rd_rem_q == BEAT_W'(1)) ? rd_last_keep_q : '1;
    assign rd_cmd_fire_c  = s_axis_mem_read_cmd_tvalid && rd_cmd_rdy_q;
    assign rd_beat_fire_c = rd_tvalid_q && m_axis_mem_read_data_tready;
    assign wr_cmd_fire_c  = s_axis_mem_write_cmd_tvalid && wr_cmd_rdy_q;
    assign wr_data_fire_c = s_axis_mem_write_data_tvalid && wr_data_rdy_q;
    // Address bits outside the word index are ignored by contract.
    assign unused_bits_c  = ^{s_axis_mem_read_cmd_tdata[63:6+IDX_W], s_axis_mem_read_cmd_tdata[5:0],
                              s_axis_mem_write_cmd_tdata[63:6+IDX_W], s_axis_mem_write_cmd_tdata[5:0]};

    // Read FSM: one prefetch cycle, then a word is reloaded on every accepted beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state_q     <= RD_IDLE;
            rd_idx_q       <= '0;
            rd_rem_q       <= '0;
            rd_last_keep_q <= '0;
            rd_cnt_q       <= '0;
            rd_stall_q     <= 1'b0;
            rd_cmd_rdy_q   <= 1'b0;
            rd_tdata_q     <= '0;
            rd_tkeep_q     <= '0;
            rd_tlast_q     <= 1'b0;
            rd_tvalid_q    <= 1'b0;
        end else begin
            case (rd_state_q)
                RD_IDLE: begin
                    if (!rd_cmd_rdy_q) begin
                        rd_cmd_rdy_q <= 1'b1;
                    end else if (rd_cmd_fire_c && rd_cmd_beats_c != '0) begin
                        rd_idx_q       <= s_axis_mem_read_cmd_tdata[6 +: IDX_W];
                        rd_rem_q       <= rd_cmd_beats_c;
                        rd_last_keep_q <= last_keep_of(s_axis_mem_read_cmd_tdata[69:64]);
                        rd_cnt_q       <= '0;
                        rd_cmd_rdy_q   <= 1'b0;
                        rd_state_q     <= RD_LOAD;
                    end
                end
                RD_LOAD: begin
                    rd_tdata_q  <= mem_q[rd_idx_q];
                    rd_tkeep_q  <= rd_load_keep_c;
                    rd_tlast_q  <= (rd_rem_q == BEAT_W'(1));
                    rd_tvalid_q <= 1'b1;
                    rd_idx_q    <= rd_idx_q + IDX_W'(1);
                    rd_rem_q    <= rd_rem_q - BEAT_W'(1);
                    rd_state_q  <= RD_STREAM;
                end
                RD_STREAM: begin
                    if (rd_stall_q) begin
                        rd_tdata_q  <= mem_q[rd_idx_q];
                        rd_tkeep_q  <= rd_load_keep_c;
                        rd_tlast_q  <= (rd_rem_q == BEAT_W'(1));
                        rd_tvalid_q <= 1'b1;
                        rd_idx_q    <= rd_idx_q + IDX_W'(1);
                        rd_rem_q    <= rd_rem_q - BEAT_W'(1);
                        rd_stall_q  <= 1'b0;
                    end else if (rd_beat_fire_c) begin
                        if (rd_rem_q == '0) begin
                            rd_tvalid_q  <= 1'b0;
                            rd_tlast_q   <= 1'b0;
                            rd_cmd_rdy_q <= 1'b1;
                            rd_state_q   <= RD_IDLE;
                        end else if (StallEn && rd_cnt_q == CNT_W'(STALL_PERIOD - 1)) begin
                            rd_tvalid_q <= 1'b0;
                            rd_stall_q  <= 1'b1;
                            rd_cnt_q    <= '0;
                        end else begin
                            rd_tdata_q  <= mem_q[rd_idx_q];
                            rd_tkeep_q  <= rd_load_keep_c;
                            rd_tlast_q  <= (rd_rem_q == BEAT_W'(1));
                            rd_idx_q    <= rd_idx_q + IDX_W'(1);
                            rd_rem_q    <= rd_rem_q - BEAT_W'(1);
                            rd_cnt_q    <= rd_cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: rd_state_q <= RD_IDLE;
            endcase
        end
    end

    // Write FSM: command first, then exactly the commanded number of data beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state_q    <= WR_IDLE;
            wr_idx_q      <= '0;
            wr_rem_q      <= '0;
            wr_cmd_rdy_q  <= 1'b0;
            wr_data_rdy_q <= 1'b0;
        end else begin
            case (wr_state_q)
                WR_IDLE: begin
                    if (!wr_cmd_rdy_q) begin
                        wr_cmd_rdy_q <= 1'b1;
                    end else if (wr_cmd_fire_c && wr_cmd_beats_c != '0) begin
                        wr_idx_q      <= s_axis_mem_write_cmd_tdata[6 +: IDX_W];
                        wr_rem_q      <= wr_cmd_beats_c;
                        wr_cmd_rdy_q  <= 1'b0;
                        wr_data_rdy_q <= 1'b1;
                        wr_state_q    <= WR_DATA;
                    end
                end
                WR_DATA: begin
                    if (wr_data_fire_c) begin
                        wr_idx_q <= wr_idx_q + IDX_W'(1);
                        wr_rem_q <= wr_rem_q - BEAT_W'(1);
                        if (wr_rem_q == BEAT_W'(1)) begin
                            wr_data_rdy_q <= 1'b0;
                            wr_cmd_rdy_q  <= 1'b1;
                            wr_state_q    <= WR_IDLE;
                        end
                    end
                end
                default: wr_state_q <= WR_IDLE;
            endcase
        end
    end

    // Byte-enabled commit; the array deliberately survives reset.
    always_ff @(posedge clk) begin
        if (wr_data_fire_c) begin
            for (int b = 0; b < KEEP_W; b++) begin
                if (s_axis_mem_write_data_tkeep[b]) begin
                    mem_q[wr_idx_q][8*b +: 8] <= s_axis_mem_write_data_tdata[8*b +: 8];
                end
            end
        end
    end

    assign s_axis_mem_read_cmd_tready   = rd_cmd_rdy_q;
    assign m_axis_mem_read_data_tdata   = rd_tdata_q;
    assign m_axis_mem_read_data_tkeep   = rd_tkeep_q;
    assign m_axis_mem_read_data_tlast   = rd_tlast_q;
    assign m_axis_mem_read_data_tvalid  = rd_tvalid_q;
    assign s_axis_mem_write_cmd_tready  = wr_cmd_rdy_q;
    assign s_axis_mem_write_data_tready = wr_data_rdy_q;
endmodule
